neo_receiver: RTL and testbench
===============================

NEO_RECEIVER -- requirements
Module: neo_receiver

Interface
REQ-001 SHALL have parameter LED_NUM_MAX, default 2, meaning number of 24-bit words captured per frame before forwarding starts.
REQ-002 SHALL have parameter BIT1_THRESH, default 8, meaning the minimum high-pulse length in clocks decoded as '1'.
REQ-003 SHALL have parameter MAX_HIGH, default 20, meaning the high-pulse length in clocks that flags a glitch error.
REQ-004 SHALL have parameter RESET_CLKS, default 625, meaning the low-run length in clocks (50 us at 12.5 MHz) treated as latch/reset gap.
REQ-005 SHALL have port clk_over_4, input, 1 bit: sole clock, 12.5 MHz.
REQ-006 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port din, input, 1 bit: asynchronous WS2812-style serial line.
REQ-008 SHALL have port color_valid, output, 1 bit: one-cycle pulse when a word completes.
REQ-009 SHALL have port color_data, output, 24 bits: the decoded word; held until the next color_valid.
REQ-010 SHALL have port color_idx, output, $clog2(LED_NUM_MAX) bits: the word index within the frame.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the latch gap.
REQ-012 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a glitch or a partial word.
REQ-013 SHALL have port dout, output, 1 bit: pass-through of bits beyond LED_NUM_MAX words.

Function
REQ-014 din SHALL pass a 2-flop synchronizer; all decoding uses the synchronized din_s and its previous value.
REQ-015 The FSM SHALL have states WAIT_GAP, IDLE, HIGH and LOW.
REQ-016 WAIT_GAP SHALL count consecutive low clocks and move to IDLE when the count reaches RESET_CLKS; any high restarts the count.
REQ-017 IDLE or LOW SHALL move to HIGH on a din_s rising edge and clear the high counter.
REQ-018 HIGH SHALL count clocks; on the falling edge the bit SHALL be 1 if the count is >= BIT1_THRESH, else 0, and the state SHALL move to LOW.
REQ-019 If the high count reaches MAX_HIGH, the block SHALL pulse frame_err, discard the partial word, and move to WAIT_GAP.
REQ-020 Bits SHALL be stored LSB-first: the first bit of a word goes to bit 0 and the 24th to bit 23.
REQ-021 The 5-bit bit counter SHALL wrap from 23 to 0 on word completion.
REQ-022 On the 24th bit of a word with index < LED_NUM_MAX, color_valid SHALL pulse in the cycle the falling edge is sampled, with color_data/color_idx updated in the same cycle; latency from the din fall is 3 clocks.
REQ-023 Words with index >= LED_NUM_MAX SHALL produce no color_valid.
REQ-024 The word index SHALL saturate at LED_NUM_MAX.
REQ-025 Once LED_NUM_MAX words are captured, dout SHALL equal din_s; otherwise dout SHALL be 0.
REQ-026 In LOW, a low run reaching RESET_CLKS SHALL pulse frame_done once, move to IDLE, and clear the word index, bit counter and forwarding.
REQ-027 If the bit counter is nonzero at the gap, frame_err SHALL pulse in the same cycle as frame_done.
REQ-028 The low counter SHALL saturate at RESET_CLKS and SHALL NOT re-pulse.
REQ-029 A gap in IDLE with no bits received SHALL NOT pulse frame_done.
REQ-030 A rising edge on the same cycle the low count hits RESET_CLKS SHALL take priority: no frame_done, go to HIGH.

Reset
REQ-031 While rstn = 0, all outputs SHALL be 0, the synchronizer SHALL be 0, all counters SHALL be 0, and the state SHALL be WAIT_GAP.
REQ-032 Reset mid-frame SHALL discard all partial data; after release the block SHALL wait for a full gap before decoding.

Structure
REQ-033 A shared package SHALL hold the state enumeration and the timing constants (BIT1_THRESH, MAX_HIGH, RESET_CLKS defaults, word width 24).
REQ-034 The synchronizer SHALL be one sub-module, neo_sync2; all other logic SHALL be in neo_receiver.

Verification
REQ-035 Scenario: after reset, hold din low 625 clocks, then send 0x00FF00 LSB-first ('1' = 12 high/4 low, '0' = 4 high/12 low) -> color_valid with color_data = 0x00FF00 and idx = 0.
REQ-036 Scenario: send 2 words 0x123456 and 0xABCDEF, then 8192 low clocks -> 2 color_valid pulses (idx 0, 1), then exactly 1 frame_done and no frame_err.
REQ-037 Scenario: send 3 words -> the third word produces no color_valid, and dout replicates its 24 pulses delayed 2 clocks.
REQ-038 Scenario: send 10 bits, then a 700-clock low -> frame_done and frame_err in the same cycle, then the next word decodes correctly from idx 0.
REQ-039 Scenario: a 25-clock high pulse -> frame_err at clock 20 of the pulse, and no decoding until a 625-clock low run.
REQ-040 Scenario: assert rstn low at bit 12 of a word -> outputs 0 immediately; after release, bits sent without a preceding gap are ignored.

Source files
------------

// File: rtl/neo_pkg.sv
// neo_pkg: state encoding and timing defaults shared by the WS2812 receiver
package neo_pkg;
    localparam int WORD_W          = 24;
    localparam int BIT1_THRESH_DEF = 8;
    localparam int MAX_HIGH_DEF    = 20;
    localparam int RESET_CLKS_DEF  = 625;
    typedef enum logic [1:0] {WAIT_GAP, IDLE, HIGH, LOW} state_t;
endpackage

// File: rtl/neo_sync2.sv
// neo_sync2: two-flop synchronizer for the asynchronous serial line
module neo_sync2 (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) {o_q, r_meta} <= 2'b00;
        else         {o_q, r_meta} <= {r_meta, i_d};
    end
endmodule

// File: rtl/neo_receiver.sv
// neo_receiver: WS2812 pulse-width decoder capturing LED_NUM_MAX words, then forwarding the line
module neo_receiver
    import neo_pkg::*;
#(
    parameter int LED_NUM_MAX = 2,
    parameter int BIT1_THRESH = BIT1_THRESH_DEF,
    parameter int MAX_HIGH    = MAX_HIGH_DEF,
    parameter int RESET_CLKS  = RESET_CLKS_DEF
) (
    input  logic                                                clk_over_4,
    input  logic                                                rstn,
    input  logic                                                din,
    output logic                                                color_valid,
    output logic [WORD_W-1:0]                                   color_data,
    output logic [(LED_NUM_MAX > 1 ? $clog2(LED_NUM_MAX) : 1)-1:0] color_idx,
    output logic                                                frame_done,
    output logic                                                frame_err,
    output logic                                                dout
);
    localparam int IDX_W  = LED_NUM_MAX > 1 ? $clog2(LED_NUM_MAX) : 1;
    localparam int WI_W   = $clog2(LED_NUM_MAX + 1);
    localparam int LOW_W  = $clog2(RESET_CLKS + 1);
    localparam int HIGH_W = $clog2(MAX_HIGH + 1);

    state_t            r_state, w_state_nx;
    logic              w_din_s, r_din_d;
    logic [LOW_W-1:0]  r_low_cnt;
    logic [HIGH_W-1:0] r_high_cnt;
    logic [4:0]        r_bit_cnt;
    logic [WORD_W-1:0] r_shift;
    logic [WI_W-1:0]   r_word_idx;
    logic              r_fwd;
    logic              w_rise, w_fall, w_low_hit, w_high_hit, w_bit;
    logic              w_bit_done, w_glitch, w_gap, w_word_done, w_capture;

    neo_sync2 u_sync (.i_clk(clk_over_4), .i_rstn(rstn), .i_d(din), .o_q(w_din_s));

    assign w_rise      = w_din_s & ~r_din_d;
    assign w_fall      = ~w_din_s & r_din_d;
    assign w_low_hit   = ~w_din_s && r_low_cnt == LOW_W'(RESET_CLKS - 1);
    assign w_high_hit  = w_din_s && r_high_cnt == HIGH_W'(MAX_HIGH - 1);
    assign w_bit       = r_high_cnt >= HIGH_W'(BIT1_THRESH);
    assign w_word_done = w_bit_done && r_bit_cnt == 5'd23;
    assign w_capture   = w_word_done && r_word_idx < WI_W'(LED_NUM_MAX);
    assign dout        = r_fwd & w_din_s;

    always_ff @(posedge clk_over_4 or negedge rstn) begin
        if (!rstn) r_state <= WAIT_GAP;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_bit_done = 1'b0;
        w_glitch   = 1'b0;
        w_gap      = 1'b0;
        case (r_state)
            WAIT_GAP: w_state_nx = w_low_hit ? IDLE : WAIT_GAP;
            IDLE, LOW: begin
                w_state_nx = w_rise ? HIGH : (w_low_hit ? IDLE : r_state);
                w_gap      = r_state == LOW && w_low_hit;
            end
            HIGH: begin
                w_bit_done = w_fall;
                w_glitch   = w_high_hit;
                w_state_nx = w_fall ? LOW : (w_high_hit ? WAIT_GAP : HIGH);
            end
            default: w_state_nx = WAIT_GAP;
        endcase
    end

    always_ff @(posedge clk_over_4 or negedge rstn) begin
        if (!rstn) begin
            r_din_d     <= 1'b0;
            r_low_cnt   <= '0;
            r_high_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_word_idx  <= '0;
            r_fwd       <= 1'b0;
            color_valid <= 1'b0;
            color_data  <= '0;
            color_idx   <= '0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            r_din_d     <= w_din_s;
            r_low_cnt   <= w_din_s ? '0 : (r_low_cnt == LOW_W'(RESET_CLKS) ? r_low_cnt : r_low_cnt + 1'b1);
            // the rising clock itself is the first clock of the high pulse
            r_high_cnt  <= w_rise ? HIGH_W'(1) : (r_state == HIGH ? r_high_cnt + 1'b1 : r_high_cnt);
            color_valid <= w_capture;
            frame_done  <= w_gap;
            frame_err   <= w_glitch | (w_gap && r_bit_cnt != 5'd0);
            if (w_bit_done) begin
                r_shift   <= {w_bit, r_shift[WORD_W-1:1]};
                r_bit_cnt <= w_word_done ? 5'd0 : r_bit_cnt + 5'd1;
            end
            if (w_capture) begin
                color_data <= {w_bit, r_shift[WORD_W-1:1]};
                color_idx  <= r_word_idx[IDX_W-1:0];
                r_word_idx <= r_word_idx + 1'b1;
                r_fwd      <= r_word_idx == WI_W'(LED_NUM_MAX - 1);
            end
            if (w_glitch) r_bit_cnt <= '0;
            if (w_low_hit) begin
                r_bit_cnt  <= '0;
                r_word_idx <= '0;
                r_fwd      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_neo_receiver.sv
// tb_neo_receiver: directed WS2812 frames against a scoreboard of expected words
module tb_neo_receiver;
    logic        clk_over_4 = 1'b0, rstn = 1'b0, din = 1'b0;
    logic        color_valid, frame_done, frame_err, dout;
    logic [23:0] color_data;
    logic        color_idx;

    typedef struct { logic [23:0] data; logic idx; int cyc; } exp_t;
    exp_t exp_q[$];

    int   vectors = 0, miscompares = 0;
    int   cyc = 0, valid_cnt = 0, done_cnt = 0, err_cnt = 0, done_cyc = -1, err_cyc = -1, last_fall = 0;
    int   dout_bad = 0, dout_rises = 0;
    logic chk_dout = 1'b0, d1 = 1'b0, d2 = 1'b0, dout_q = 1'b0;

    neo_receiver #(.LED_NUM_MAX(2)) dut (
        .clk_over_4 (clk_over_4),
        .rstn       (rstn),
        .din        (din),
        .color_valid(color_valid),
        .color_data (color_data),
        .color_idx  (color_idx),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .dout       (dout)
    );

    always #40 clk_over_4 = ~clk_over_4;

    always @(posedge clk_over_4) begin
        cyc++;
        d2 = d1;
        d1 = din;
    end

    always @(negedge clk_over_4) begin
        exp_t e;
        if (color_valid) begin
            valid_cnt++;
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_valid: observed data=%h idx=%0d, expected no pulse", color_data, color_idx);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                assert (color_data === e.data && color_idx === e.idx) else begin
                    miscompares++;
                    $error("FAIL word: observed data=%h idx=%0d, expected data=%h idx=%0d", color_data, color_idx, e.data, e.idx);
                end
                vectors++;
                assert (cyc === e.cyc) else begin
                    miscompares++;
                    $error("FAIL valid_latency: observed cycle %0d, expected cycle %0d", cyc, e.cyc);
                end
            end
        end
        if (frame_done) begin done_cnt++; done_cyc = cyc; end
        if (frame_err)  begin err_cnt++;  err_cyc  = cyc; end
        if (chk_dout) begin
            dout_bad   += int'(dout !== d2);
            dout_rises += int'(dout && !dout_q);
        end
        dout_q = dout;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic hold(input logic v, input int n);
        din = v;
        repeat (n) @(negedge clk_over_4);
    endtask

    // LSB first: '1' = 12 high / 4 low, '0' = 4 high / 12 low
    task automatic send_bits(input logic [23:0] w, input int n, input logic expect_v, input logic idx);
        for (int i = 0; i < n; i++) begin
            hold(1'b1, w[i] ? 12 : 4);
            last_fall = cyc;
            if (expect_v && i == 23) exp_q.push_back('{w, idx, cyc + 3});
            hold(1'b0, w[i] ? 4 : 12);
        end
    endtask

    initial begin
        int v0, d0, e0, r;
        repeat (2) @(negedge clk_over_4);
        check("reset_outputs", {35'd0, color_valid, color_data, color_idx, frame_done, frame_err, dout}, 64'd0);
        rstn = 1'b1;
        hold(1'b0, 640);
        check("no_done_on_initial_gap", done_cnt, 0);

        send_bits(24'h00FF00, 24, 1'b1, 1'b0);
        hold(1'b0, 700);
        check("first_word_valids", valid_cnt, 1);
        check("first_gap_done", done_cnt, 1);
        check("first_gap_done_cycle", done_cyc, last_fall + 627);
        check("first_gap_no_err", err_cnt, 0);

        v0 = valid_cnt; d0 = done_cnt; e0 = err_cnt;
        send_bits(24'h123456, 24, 1'b1, 1'b0);
        send_bits(24'hABCDEF, 24, 1'b1, 1'b1);
        hold(1'b0, 8192);
        check("two_words_valids", valid_cnt - v0, 2);
        check("long_gap_single_done", done_cnt - d0, 1);
        check("long_gap_done_cycle", done_cyc, last_fall + 627);
        check("two_words_no_err", err_cnt - e0, 0);

        v0 = valid_cnt; d0 = done_cnt; e0 = err_cnt;
        send_bits(24'hC3A50F, 24, 1'b1, 1'b0);
        send_bits(24'h5A0FF0, 24, 1'b1, 1'b1);
        chk_dout = 1'b1;
        send_bits(24'hF00DF0, 24, 1'b0, 1'b0);
        hold(1'b0, 3);
        chk_dout = 1'b0;
        check("third_word_no_valid", valid_cnt - v0, 2);
        check("dout_follows_din_2clk", dout_bad, 0);
        check("dout_pulse_count", dout_rises, 24);
        hold(1'b0, 700);
        check("three_words_done", done_cnt - d0, 1);
        check("three_words_no_err", err_cnt - e0, 0);

        d0 = done_cnt; e0 = err_cnt;
        send_bits(24'h0002AB, 10, 1'b0, 1'b0);
        hold(1'b0, 700);
        check("partial_done", done_cnt - d0, 1);
        check("partial_err", err_cnt - e0, 1);
        check("partial_done_err_same_cycle", done_cyc, err_cyc);
        check("partial_done_cycle", done_cyc, last_fall + 627);
        send_bits(24'h5A5A5A, 24, 1'b1, 1'b0);
        hold(1'b0, 700);
        check("after_partial_queue_empty", exp_q.size(), 0);

        v0 = valid_cnt; d0 = done_cnt; e0 = err_cnt;
        r = cyc;
        hold(1'b1, 25);
        hold(1'b0, 12);
        check("glitch_err", err_cnt - e0, 1);
        check("glitch_err_cycle", err_cyc, r + 22);
        send_bits(24'hFFFFFF, 24, 1'b0, 1'b0);
        check("glitch_no_decode", valid_cnt - v0, 0);
        hold(1'b0, 640);
        send_bits(24'h0F0F0F, 24, 1'b1, 1'b0);
        hold(1'b0, 700);
        check("glitch_recover_valid", valid_cnt - v0, 1);
        check("glitch_recover_done", done_cnt - d0, 1);
        check("glitch_total_err", err_cnt - e0, 1);

        v0 = valid_cnt; d0 = done_cnt; e0 = err_cnt;
        send_bits(24'hABCDEF, 12, 1'b0, 1'b0);
        rstn = 1'b0;
        #1;
        check("midframe_reset_outputs", {35'd0, color_valid, color_data, color_idx, frame_done, frame_err, dout}, 64'd0);
        repeat (3) @(negedge clk_over_4);
        rstn = 1'b1;
        send_bits(24'h00FF00, 24, 1'b0, 1'b0);
        check("reset_no_decode_without_gap", valid_cnt - v0, 0);
        hold(1'b0, 640);
        check("reset_gap_no_done", done_cnt - d0, 0);
        send_bits(24'h33CC33, 24, 1'b1, 1'b0);
        hold(1'b0, 700);
        check("reset_recover_valid", valid_cnt - v0, 1);
        check("reset_recover_done", done_cnt - d0, 1);
        check("reset_recover_no_err", err_cnt - e0, 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
